// File: rtl/drm_32x16384_arb_pkg.sv
// drm_32x16384_arb_pkg: shared widths and the request bundle
// used by the dual-requester 32x16384 RAM arbiter.
package drm_32x16384_arb_pkg;

    localparam int DRM_ADDR_W = 14;
    localparam int DRM_DATA_W = 32;
    localparam int DRM_BE_W   = DRM_DATA_W / 8;

    typedef struct packed {
        logic                  we;
        logic [DRM_ADDR_W-1:0] addr;
        logic [DRM_DATA_W-1:0] wdata;
        logic [DRM_BE_W-1:0]   be;
    } drm_req_t;

endpackage

// File: rtl/drm_32x16384_arb_rr2.sv
// drm_rr_arb2: two-way round-robin arbiter driven by an external pointer.
// Ports: req[1:0] in, rr in (preferred side), gnt[1:0] out, contested/loser out.
module drm_rr_arb2 (
    input  logic [1:0] req,
    input  logic       rr,
    output logic [1:0] gnt,
    output logic       contested,
    output logic       loser
);

    assign contested = req[0] & req[1];
    assign gnt[0]    = req[0] & (~req[1] | ~rr);
    assign gnt[1]    = req[1] & (~req[0] | rr);
    // Under contention the winner is rr itself, so the loser is the other side.
    assign loser     = ~rr;

endmodule

// File: rtl/drm_32x16384_arb.sv
// drm_32x16384_arb: two requesters sharing one 1W/1R RAM port pair.
// Ports: clk, rst_n, req_*_0/1 in, req_ready_0/1, rsp_valid/data_0/1 out,
//        ram_wr_* out, ram_rd_addr out, ram_rd_data in (1-cycle latency RAM).
module drm_32x16384_arb
    import drm_32x16384_arb_pkg::*;
#(
    parameter int ADDR_W = DRM_ADDR_W,
    parameter int DATA_W = DRM_DATA_W,
    parameter int BE_W   = DRM_BE_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid_0,
    output logic              req_ready_0,
    input  logic              req_we_0,
    input  logic [ADDR_W-1:0] req_addr_0,
    input  logic [DATA_W-1:0] req_wdata_0,
    input  logic [BE_W-1:0]   req_be_0,
    output logic              rsp_valid_0,
    output logic [DATA_W-1:0] rsp_data_0,
    input  logic              req_valid_1,
    output logic              req_ready_1,
    input  logic              req_we_1,
    input  logic [ADDR_W-1:0] req_addr_1,
    input  logic [DATA_W-1:0] req_wdata_1,
    input  logic [BE_W-1:0]   req_be_1,
    output logic              rsp_valid_1,
    output logic [DATA_W-1:0] rsp_data_1,
    output logic              ram_wr_en,
    output logic [ADDR_W-1:0] ram_wr_addr,
    output logic [DATA_W-1:0] ram_wr_data,
    output logic [BE_W-1:0]   ram_wr_byte_en,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic [DATA_W-1:0] ram_rd_data
);

    drm_req_t req [2];

    assign req[0] = '{we: req_we_0, addr: req_addr_0,
                      wdata: req_wdata_0, be: req_be_0};
    assign req[1] = '{we: req_we_1, addr: req_addr_1,
                      wdata: req_wdata_1, be: req_be_1};

    logic       rr;
    logic       rr_d;
    logic [1:0] rd_req;
    logic [1:0] wr_req;
    logic [1:0] rd_gnt;
    logic [1:0] wr_gnt;
    logic       rd_contest;
    logic       wr_contest;
    logic       rd_loser;
    logic       wr_loser;

    // Nothing is accepted while reset is held.
    assign rd_req[0] = rst_n & req_valid_0 & ~req[0].we;
    assign rd_req[1] = rst_n & req_valid_1 & ~req[1].we;
    assign wr_req[0] = rst_n & req_valid_0 & req[0].we;
    assign wr_req[1] = rst_n & req_valid_1 & req[1].we;

    drm_rr_arb2 u_rd_arb (
        .req       (rd_req),
        .rr        (rr),
        .gnt       (rd_gnt),
        .contested (rd_contest),
        .loser     (rd_loser)
    );

    drm_rr_arb2 u_wr_arb (
        .req       (wr_req),
        .rr        (rr),
        .gnt       (wr_gnt),
        .contested (wr_contest),
        .loser     (wr_loser)
    );

    assign req_ready_0 = rd_gnt[0] | wr_gnt[0];
    assign req_ready_1 = rd_gnt[1] | wr_gnt[1];

    // Read and write cannot both be contested: there are only two requesters.
    always_comb begin
        rr_d = rr;
        if (rd_contest) begin
            rr_d = rd_loser;
        end else if (wr_contest) begin
            rr_d = wr_loser;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr <= 1'b0;
        end else begin
            rr <= rr_d;
        end
    end

    always_comb begin
        ram_wr_en      = 1'b0;
        ram_wr_addr    = '0;
        ram_wr_data    = '0;
        ram_wr_byte_en = '0;
        unique case (1'b1)
            wr_gnt[0]: begin
                ram_wr_en      = 1'b1;
                ram_wr_addr    = req[0].addr;
                ram_wr_data    = req[0].wdata;
                ram_wr_byte_en = req[0].be;
            end
            wr_gnt[1]: begin
                ram_wr_en      = 1'b1;
                ram_wr_addr    = req[1].addr;
                ram_wr_data    = req[1].wdata;
                ram_wr_byte_en = req[1].be;
            end
            default: ;
        endcase
    end

    logic              rd_any;
    logic [ADDR_W-1:0] rd_addr_cur;
    logic [ADDR_W-1:0] rd_addr_q;

    assign rd_any      = |rd_gnt;
    assign rd_addr_cur = rd_gnt[1] ? req[1].addr : req[0].addr;
    assign ram_rd_addr = rd_any ? rd_addr_cur : rd_addr_q;

    // rd_addr_q doubles as the address of the read now in the RAM stage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_addr_q <= '0;
        end else if (rd_any) begin
            rd_addr_q <= rd_addr_cur;
        end
    end

    // Forward entry 0 = write of the previous cycle, entry 1 = the one before.
    // At capture time these are the writes of cycles N and N-1 of the read.
    logic              fwd_valid [2];
    logic [ADDR_W-1:0] fwd_addr  [2];
    logic [DATA_W-1:0] fwd_data  [2];
    logic [BE_W-1:0]   fwd_be    [2];
    logic [1:0]        fwd_hit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                fwd_valid[k] <= 1'b0;
                fwd_addr[k]  <= '0;
                fwd_data[k]  <= '0;
                fwd_be[k]    <= '0;
            end
        end else begin
            fwd_valid[0] <= ram_wr_en;
            fwd_addr[0]  <= ram_wr_addr;
            fwd_data[0]  <= ram_wr_data;
            fwd_be[0]    <= ram_wr_byte_en;
            fwd_valid[1] <= fwd_valid[0];
            fwd_addr[1]  <= fwd_addr[0];
            fwd_data[1]  <= fwd_data[0];
            fwd_be[1]    <= fwd_be[0];
        end
    end

    assign fwd_hit[0] = fwd_valid[0] && (fwd_addr[0] == rd_addr_q);
    assign fwd_hit[1] = fwd_valid[1] && (fwd_addr[1] == rd_addr_q);

    logic [DATA_W-1:0] merged;

    // Older entry first so the newer write wins on overlapping bytes.
    always_comb begin
        merged = ram_rd_data;
        for (int b = 0; b < BE_W; b++) begin
            if (fwd_hit[1] && fwd_be[1][b]) begin
                merged[8*b +: 8] = fwd_data[1][8*b +: 8];
            end
            if (fwd_hit[0] && fwd_be[0][b]) begin
                merged[8*b +: 8] = fwd_data[0][8*b +: 8];
            end
        end
    end

    logic s1_valid;
    logic s1_id;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid    <= 1'b0;
            s1_id       <= 1'b0;
            rsp_valid_0 <= 1'b0;
            rsp_valid_1 <= 1'b0;
            rsp_data_0  <= '0;
            rsp_data_1  <= '0;
        end else begin
            s1_valid    <= rd_any;
            s1_id       <= rd_gnt[1];
            rsp_valid_0 <= s1_valid & ~s1_id;
            rsp_valid_1 <= s1_valid & s1_id;
            if (s1_valid && !s1_id) begin
                rsp_data_0 <= merged;
            end
            if (s1_valid && s1_id) begin
                rsp_data_1 <= merged;
            end
        end
    end

endmodule

// File: tb/tb_drm_32x16384_arb.sv
// tb_drm_32x16384_arb: directed bench with a RAM model, a reference
// memory and per-requester response scoreboards.
module tb_drm_32x16384_arb;

    localparam int AW = 14;
    localparam int DW = 32;
    localparam int BW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid_0, req_ready_0, req_we_0;
    logic [AW-1:0] req_addr_0;
    logic [DW-1:0] req_wdata_0;
    logic [BW-1:0] req_be_0;
    logic          rsp_valid_0;
    logic [DW-1:0] rsp_data_0;
    logic          req_valid_1, req_ready_1, req_we_1;
    logic [AW-1:0] req_addr_1;
    logic [DW-1:0] req_wdata_1;
    logic [BW-1:0] req_be_1;
    logic          rsp_valid_1;
    logic [DW-1:0] rsp_data_1;
    logic          ram_wr_en;
    logic [AW-1:0] ram_wr_addr;
    logic [DW-1:0] ram_wr_data;
    logic [BW-1:0] ram_wr_byte_en;
    logic [AW-1:0] ram_rd_addr;
    logic [DW-1:0] ram_rd_data;

    always #5 clk = ~clk;

    drm_32x16384_arb dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_0(req_valid_0), .req_ready_0(req_ready_0),
        .req_we_0(req_we_0), .req_addr_0(req_addr_0),
        .req_wdata_0(req_wdata_0), .req_be_0(req_be_0),
        .rsp_valid_0(rsp_valid_0), .rsp_data_0(rsp_data_0),
        .req_valid_1(req_valid_1), .req_ready_1(req_ready_1),
        .req_we_1(req_we_1), .req_addr_1(req_addr_1),
        .req_wdata_1(req_wdata_1), .req_be_1(req_be_1),
        .rsp_valid_1(rsp_valid_1), .rsp_data_1(rsp_data_1),
        .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr),
        .ram_wr_data(ram_wr_data), .ram_wr_byte_en(ram_wr_byte_en),
        .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old,
                                            input logic [DW-1:0] nw,
                                            input logic [BW-1:0] be);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < BW; b++) begin
            if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        end
        return r;
    endfunction

    // RAM model: registered address, read-first, byte-enabled write.
    logic [DW-1:0] mem     [2**AW];
    logic [DW-1:0] ref_mem [2**AW];

    always @(posedge clk) begin
        if (ram_wr_en) begin
            mem[ram_wr_addr] <= merge(mem[ram_wr_addr], ram_wr_data,
                                      ram_wr_byte_en);
        end
        ram_rd_data <= mem[ram_rd_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          q0[$];
    exp_t          q1[$];
    logic [DW-1:0] last0, last1;
    int            n_rsp0 = 0;
    int            n_rsp1 = 0;

    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst_n) begin
            q0.delete();
            q1.delete();
        end else begin
            if (rsp_valid_0) begin
                n_rsp0++;
                last0 = rsp_data_0;
                if (q0.size() == 0) begin
                    check("rsp0_unexpected", 1, 0);
                end else begin
                    e = q0.pop_front();
                    check("rsp0_latency", cyc, e.due);
                    check("rsp0_data", rsp_data_0, e.data);
                end
            end else if (q0.size() > 0 && q0[0].due <= cyc) begin
                e = q0.pop_front();
                check("rsp0_missing", 0, 1);
            end
            if (rsp_valid_1) begin
                n_rsp1++;
                last1 = rsp_data_1;
                if (q1.size() == 0) begin
                    check("rsp1_unexpected", 1, 0);
                end else begin
                    e = q1.pop_front();
                    check("rsp1_latency", cyc, e.due);
                    check("rsp1_data", rsp_data_1, e.data);
                end
            end else if (q1.size() > 0 && q1[0].due <= cyc) begin
                e = q1.pop_front();
                check("rsp1_missing", 0, 1);
            end
            if (req_valid_0 && req_ready_0 && req_we_0)
                ref_mem[req_addr_0] = merge(ref_mem[req_addr_0],
                                            req_wdata_0, req_be_0);
            if (req_valid_1 && req_ready_1 && req_we_1)
                ref_mem[req_addr_1] = merge(ref_mem[req_addr_1],
                                            req_wdata_1, req_be_1);
            if (req_valid_0 && req_ready_0 && !req_we_0)
                q0.push_back('{cyc + 2, ref_mem[req_addr_0]});
            if (req_valid_1 && req_ready_1 && !req_we_1)
                q1.push_back('{cyc + 2, ref_mem[req_addr_1]});
        end
    end

    task automatic drive(input int i, input logic v, input logic we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [BW-1:0] be);
        if (i == 0) begin
            req_valid_0 = v; req_we_0 = we; req_addr_0 = a;
            req_wdata_0 = d; req_be_0 = be;
        end else begin
            req_valid_1 = v; req_we_1 = we; req_addr_1 = a;
            req_wdata_1 = d; req_be_1 = be;
        end
    endtask

    task automatic idle_all();
        drive(0, 0, 0, '0, '0, '0);
        drive(1, 0, 0, '0, '0, '0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int notready;
        int snap;
        for (int i = 0; i < 2**AW; i++) begin
            mem[i] = 32'hC0DE_0000 | 32'(i);
        end
        mem[5] = 32'hAABB_CCDD;
        for (int i = 0; i < 2**AW; i++) ref_mem[i] = mem[i];

        // Reset: requests present but nothing may be accepted.
        drive(0, 1, 0, 14'h0010, '0, '0);
        drive(1, 1, 1, 14'h0011, 32'h1234_5678, 4'hF);
        tick();
        mid();
        check("rst_ready", {req_ready_1, req_ready_0}, 2'b00);
        check("rst_wr_en", ram_wr_en, 0);
        tick();
        rst_n = 1'b1;
        idle_all();
        mid();
        check("rel_ready", {req_ready_1, req_ready_0}, 2'b00);
        check("rel_rsp_valid", {rsp_valid_1, rsp_valid_0}, 2'b00);
        check("rel_rsp_data", {rsp_data_1, rsp_data_0}, 64'h0);
        check("rel_wr", {ram_wr_en, ram_wr_addr, ram_wr_byte_en}, 0);
        check("rel_wr_data", ram_wr_data, 0);
        check("rel_rd_addr", ram_rd_addr, 0);
        tick();

        // Contested reads alternate starting from requester 0.
        drive(0, 1, 0, 14'h0010, '0, '0);
        drive(1, 1, 0, 14'h0020, '0, '0);
        for (int k = 0; k < 4; k++) begin
            mid();
            check("alt_ready", {req_ready_1, req_ready_0},
                  (k % 2 == 1) ? 2'b10 : 2'b01);
            check("alt_rd_addr", ram_rd_addr,
                  (k % 2 == 1) ? 14'h0020 : 14'h0010);
            tick();
        end
        idle_all();
        tick();
        tick();
        mid();
        check("alt_n_rsp", {n_rsp1[7:0], n_rsp0[7:0]}, 16'h0202);
        check("alt_data0", last0, 32'hC0DE_0010);
        check("alt_hold1", rsp_data_1, 32'hC0DE_0020);
        check("rd_addr_hold", ram_rd_addr, 14'h0020);
        tick();

        // Concurrent write (req0) and read (req1).
        drive(0, 1, 1, 14'h3FFF, 32'hDEAD_BEEF, 4'hF);
        drive(1, 1, 0, 14'h0000, '0, '0);
        mid();
        check("conc_ready", {req_ready_1, req_ready_0}, 2'b11);
        check("conc_wr", {ram_wr_en, ram_wr_addr}, {1'b1, 14'h3FFF});
        check("conc_rd_addr", ram_rd_addr, 14'h0000);
        tick();
        idle_all();
        tick();
        tick();
        check("conc_rsp1", last1, 32'hC0DE_0000);
        check("conc_mem", mem[14'h3FFF], 32'hDEAD_BEEF);

        // Forwarding: write with partial enables, read same and next cycle.
        drive(0, 1, 1, 14'h0005, 32'h1122_3344, 4'b0101);
        drive(1, 1, 0, 14'h0005, '0, '0);
        mid();
        check("fwd_ready", {req_ready_1, req_ready_0}, 2'b11);
        check("fwd_be", ram_wr_byte_en, 4'b0101);
        tick();
        drive(0, 0, 0, '0, '0, '0);
        mid();
        check("fwd_ready2", req_ready_1, 1);
        tick();
        idle_all();
        mid();
        check("fwd_rsp_a", {rsp_valid_1, rsp_data_1}, {1'b1, 32'hAA22_CC44});
        tick();
        mid();
        check("fwd_rsp_b", {rsp_valid_1, rsp_data_1}, {1'b1, 32'hAA22_CC44});
        tick();

        // Reset right after a read is accepted.
        snap = n_rsp0;
        drive(0, 1, 0, 14'h0030, '0, '0);
        mid();
        check("mid_rst_ready", req_ready_0, 1);
        tick();
        idle_all();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        mid();
        check("mid_rst_valid", rsp_valid_0, 0);
        tick();
        tick();
        tick();
        check("mid_rst_none", n_rsp0, snap);

        // Contested writes after reset, then rr untouched by uncontested.
        drive(0, 1, 1, 14'h0100, 32'h0000_0001, 4'hF);
        drive(1, 1, 1, 14'h0101, 32'h0000_0002, 4'hF);
        mid();
        check("cw_ready_a", {req_ready_1, req_ready_0}, 2'b01);
        check("cw_addr_a", ram_wr_addr, 14'h0100);
        tick();
        mid();
        check("cw_ready_b", {req_ready_1, req_ready_0}, 2'b10);
        check("cw_data_b", ram_wr_data, 32'h0000_0002);
        tick();
        drive(0, 0, 0, '0, '0, '0);
        drive(1, 1, 1, 14'h0102, 32'h0000_0003, 4'hF);
        mid();
        check("uw_ready", {req_ready_1, req_ready_0}, 2'b10);
        tick();
        drive(0, 1, 0, 14'h0100, '0, '0);
        drive(1, 1, 0, 14'h0101, '0, '0);
        mid();
        check("rr_kept", {req_ready_1, req_ready_0}, 2'b01);
        tick();
        idle_all();
        tick();
        tick();
        tick();

        // Full sweep: req0 writes a down-counter, req1 reads one behind.
        notready = 0;
        for (int k = 0; k <= 2**AW; k++) begin
            drive(0, 1, 1, AW'(k), 32'hFFFF_FFFF - 32'(k), 4'hF);
            if (k > 0) drive(1, 1, 0, AW'(k - 1), '0, '0);
            else drive(1, 0, 0, '0, '0, '0);
            mid();
            if (!req_ready_0 || (k > 0 && !req_ready_1)) notready++;
            tick();
        end
        drive(0, 0, 0, '0, '0, '0);
        drive(1, 1, 0, 14'h0000, '0, '0);
        tick();
        idle_all();
        tick();
        tick();
        check("sweep_ready", notready, 0);
        check("sweep_wrap", last1, 32'hFFFF_BFFF);
        check("sweep_top", mem[14'h3FFF], 32'hFFFF_C000);
        tick();
        tick();
        check("drain", q0.size() + q1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
